// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide execute unit.
package muldiv_pkg;

    // Operand/result width and number of iterative steps per operation.
    localparam int MULDIV_XLEN = 32;
    localparam int MULDIV_ITER = MULDIV_XLEN;

    // funct3 encodings of the RV32M instructions.
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on unsigned magnitudes, one bit per clock, sign fix on the way out.
//
// Handshake: start is sampled on a rising edge only while busy is low; the
// op's operands, funct3 and rd_in are captured on that edge. busy is high from
// the next cycle until the result is registered; done then pulses for exactly
// one cycle (never together with busy) with result/rd_out valid, and those
// outputs hold until the next done. start in the done cycle begins a new op.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [5:0] LAST_STEP = 6'(MULDIV_ITER - 1);

    state_t            state, state_nxt;
    logic [5:0]        count;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
    logic              neg_q;    // negate product / quotient at the end
    logic              neg_r;    // negate remainder at the end

    // Operand decode for the accepting edge.
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;

    // Signedness, magnitudes and the two divide corner cases.
    always_comb begin
        a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        b_signed = a_signed && (funct3 != F3_MULHSU);
        sign_a   = a_signed && operand_a[XLEN-1];
        sign_b   = b_signed && operand_b[XLEN-1];
        a_mag    = sign_a ? -operand_a : operand_a;
        b_mag    = sign_b ? -operand_b : operand_b;
        div_zero = funct3[2] && (operand_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (operand_b == '1);
        special  = div_zero || div_ovf;
    end

    // Shared adder: accumulate the multiplicand or trial-subtract the divisor.
    logic            is_div;
    logic [XLEN+1:0] add_x, add_y, sum;

    // Operand muxing for the shared adder.
    always_comb begin
        is_div = (state == ST_DIV);
        add_x  = is_div ? {1'b0, acc[2*XLEN-1:XLEN-1]} : {2'b00, acc[2*XLEN-1:XLEN]};
        add_y  = is_div ? ~{2'b00, opnd} : {2'b00, opnd};
        sum    = add_x + add_y + {{(XLEN+1){1'b0}}, is_div};
    end

    // Sign correction and word selection applied in FIN.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin_value;

    // Final value for the completed op.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            F3_MUL:                      fin_value = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_value = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fin_value = quo;
            default:                     fin_value = rem;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; corner-case divides skip the iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (special)        state_nxt = ST_FIN;
                    else if (funct3[2]) state_nxt = ST_DIV;
                    else                state_nxt = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: if (count == LAST_STEP) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Datapath: capture, iterate, and register the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            op     <= '0;
            rd_q   <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            done <= (state == ST_FIN);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        rd_q  <= rd_in;
                        count <= '0;
                        if (div_zero) begin
                            // Quotient all ones, remainder is the raw dividend.
                            acc   <= {operand_a, {XLEN{1'b1}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else if (div_ovf) begin
                            // Quotient is the most negative value, remainder zero.
                            acc   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else if (funct3[2]) begin
                            acc   <= {{XLEN{1'b0}}, a_mag};
                            opnd  <= b_mag;
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= sign_a;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, b_mag};
                            opnd  <= a_mag;
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    acc   <= acc[0] ? {sum[XLEN:0], acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
                    count <= (count == LAST_STEP) ? '0 : count + 6'd1;
                end
                ST_DIV: begin
                    acc   <= !sum[XLEN+1] ? {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                                          : {acc[2*XLEN-2:0], 1'b0};
                    count <= (count == LAST_STEP) ? '0 : count + 6'd1;
                end
                ST_FIN: begin
                    result <= fin_value;
                    rd_out <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, randomized ops against an
// arithmetic reference model, handshake and reset-abort scenarios.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock, reset, start;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    // Clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from plain wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    // Wait (bounded) for done; n counts rising edges since the start cycle.
    task automatic wait_done(inout int n);
        while (!done && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    // Drive one op, scramble the inputs while busy, and score the completion.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clock);
        start = 1'b1; funct3 = f3; operand_a = a; operand_b = b; rd_in = rd;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        n = 1;
        start = 1'b0;
        funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        rd_in = 5'($urandom);
        check("busy_after_start", {31'h0, busy}, 32'h1);
        wait_done(n);
        check("latency", 32'(n), 32'(lat));
        check("busy_in_done", {31'h0, busy}, 32'h0);
        check("result", result, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx);
        check("rd_out", {27'h0, rd_out}, {27'h0, rd});
    endtask

    typedef struct { logic [2:0] f3; logic [31:0] a, b, exp; } vec_t;
    vec_t vecs[14];

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, dones;
        logic [2:0] f3;
        logic [31:0] a, b;

        // Reset for three cycles, then idle values.
        reset = 1'b1; start = 1'b0; funct3 = '0; operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_rd_out", {27'h0, rd_out}, 32'h0);

        // Directed cases with hand-computed expectations.
        vecs[0]  = '{F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF};
        vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14};
        vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2};
        vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{F3_REMU,   32'd5,         32'd0,         32'd5};
        vecs[10] = '{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[11] = '{F3_REM,    32'd5,         32'd0,         32'd5};
        vecs[12] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[13] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'd5, vecs[i].exp,
                   exp_latency(vecs[i].f3, vecs[i].a, vecs[i].b));

        // done is a single-cycle pulse.
        @(posedge clock);
        #1;
        check("done_one_cycle", {31'h0, done}, 32'h0);

        // Randomized ops against the model.
        for (int i = 0; i < 200; i++) begin
            f3 = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(f3, a, b, 5'($urandom), model(f3, a, b), exp_latency(f3, a, b));
        end

        // start pulsed again at E5 with other operands is ignored.
        @(negedge clock);
        start = 1'b1; funct3 = F3_MUL; operand_a = 32'd1234; operand_b = 32'd5678; rd_in = 5'd9;
        @(posedge clock);
        #1;
        n = 1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        start = 1'b1; funct3 = F3_DIVU; operand_a = 32'd77; operand_b = 32'd3; rd_in = 5'd20;
        @(posedge clock);
        #1;
        n = 5;
        start = 1'b0;
        wait_done(n);
        check("ign_latency", 32'(n), 32'd34);
        check("ign_result", result, 32'd7006652);
        check("ign_rd_out", {27'h0, rd_out}, 32'd9);

        // start held through the done cycle: second op follows immediately.
        @(negedge clock);
        start = 1'b1; funct3 = F3_MULHU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
        rd_in = 5'd3;
        @(posedge clock);
        #1;
        n = 1;
        funct3 = F3_DIVU; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd4;
        wait_done(n);
        check("b2b_first_latency", 32'(n), 32'd34);
        check("b2b_first_result", result, 32'hFFFF_FFFE);
        check("b2b_first_rd", {27'h0, rd_out}, 32'd3);
        @(posedge clock);
        #1;
        n = 1;
        start = 1'b0;
        check("b2b_second_busy", {31'h0, busy}, 32'h1);
        wait_done(n);
        check("b2b_second_latency", 32'(n), 32'd34);
        check("b2b_second_result", result, 32'd14);
        check("b2b_second_rd", {27'h0, rd_out}, 32'd4);

        // Reset after E10 aborts the op without a done pulse.
        @(negedge clock);
        start = 1'b1; funct3 = F3_MUL; operand_a = 32'd3; operand_b = 32'd4; rd_in = 5'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("abort_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_rd_out", {27'h0, rd_out}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'h0);
        check("abort_idle_busy", {31'h0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
